decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides. It is the generalised successor to the combinational Decoder. It adds:
- immediates fully assembled and sign-extended to XLEN
- LOAD/AUIPC opcodes
- illegal-instruction detection
- PC pass-through and flush

It sits between the fetch stage and the register-file/ALU stage.

Parameters:
XLEN, 32, width of out_imm and PC ports; legal values 32 or 64. Immediates are sign-extended to this width.
SKID, 1, 1 = add a skid register so in_ready is registered and throughput is full under backpressure; 0 = single register, in_ready = out_ready | ~out_valid.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction word
in_pc  in  XLEN  address of in_instr
out_valid  out  1  decoded entry available
out_ready  in  1  consumer accepts
out_op  out  7  opcode field, encoded with the RV32I.v ITYP_* macros
out_func  out  10  {funct7,funct3}; funct7 is zeroed for formats without it, except shift-immediates
out_rs1/out_rs2/out_rd  out  5 each  register indices; fields unused by the format are forced to 0
out_imm  out  XLEN  assembled, sign-extended immediate (I/S/B/U/J); B and J include bit0 = 0; U is imm<<12
out_illegal  out  1  unknown opcode or illegal funct combination
out_pc  out  XLEN  PC of the decoded instruction

Behaviour:
Reset:
- out_valid = 0, in_ready = 1, skid empty.
- All data outputs = 0.
- A reset mid-transfer discards held entries.

Transfers and latency:
- Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.

Main register:
- Loads when it is empty, or when it is emitting in the same cycle.
- SKID=1: if the main register is stalled (out_valid & ~out_ready) and an accept occurs, the decode goes into the skid register.
- in_ready = ~skid_valid, registered.
- On the next emit, skid moves to main; a new accept in that same cycle enters skid only if skid is being vacated. Ordering is preserved.
- SKID=0: no skid register; in_ready is combinational as given under Parameters.

Output stability:
- While out_valid & ~out_ready, every out_* is held stable.

Flush:
- Clears out_valid and skid_valid at the next edge.
- An accept in the flush cycle is dropped.
- Flush has priority over accept and emit.

Illegal detection:
- out_illegal = 1 when any of these holds:
  - opcode not in {R, I, S, B, U(LUI), AUIPC, J, I_SP(JALR), LOAD}
  - R-type funct7 not 0000000/0100000, or 0100000 with funct3 not ADD/SRL
  - SLLI/SRLI/SRAI with bad funct7
  - B funct3 of 010/011
  - S funct3 > 010
  - JALR funct3 != 000
- For an illegal instruction, out_imm = 0, while rs/rd keep raw fields.
- Illegal entries still handshake normally.

Decode logic:
- Purely combinational on in_instr, registered once.

Optional Feature:
DECODE_PERF_EN.
- Defined: adds outputs perf_decoded (32) and perf_illegal (32).
  - They increment on each emit, and on each emit with out_illegal.
  - They reset to 0, are unaffected by flush, and wrap at 2^32.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package/header RV32I.v gains the LOAD/AUIPC opcode macros and a format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
- The combinational field/immediate extraction is the natural sub-module decode_comb, parameterised by XLEN.
- decode_stage adds the handshake, skid and flush logic around it.

Test Plan:
1. 0x00500093 (addi x1,x0,5) -> ITYP_I, func ADDI, rs1=0, rd=1, imm=5, illegal=0, out_valid exactly 1 cycle after accept.
2. 0x402081B3 (sub x3,x1,x2) -> ITYP_R, func SUB, rs1=1, rs2=2, rd=3; 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC.
3. 0xFE20AC23 (sw x2,-8(x1)) -> imm=0xFFFFFFF8, rd=0. 0x123452B7 (lui x5,0x12345) -> imm=0x12345000. 0x008000EF (jal x1,8) -> imm=8.
4. 0xFFFFFFFF -> out_illegal=1, imm=0; with DECODE_PERF_EN after 4 emits containing 1 illegal -> perf_decoded=4, perf_illegal=1.
5. Hold out_ready=0 for 3 cycles while streaming 3 instrs (SKID=1) -> in_ready drops after 2 accepts, outputs stable; release -> 3 emits in order on consecutive cycles.
6. flush asserted with main+skid full -> next cycle out_valid=0, in_ray=1 (in_ready=1); rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// RV32I decode definitions: opcode encodings, format enum, decoded bundle.
// Shared by decode_comb and decode_stage.
package decode_stage_pkg;

  localparam logic [6:0] ITYP_R     = 7'b0110011;
  localparam logic [6:0] ITYP_I     = 7'b0010011;
  localparam logic [6:0] ITYP_S     = 7'b0100011;
  localparam logic [6:0] ITYP_B     = 7'b1100011;
  localparam logic [6:0] ITYP_U     = 7'b0110111;
  localparam logic [6:0] ITYP_AUIPC = 7'b0010111;
  localparam logic [6:0] ITYP_J     = 7'b1101111;
  localparam logic [6:0] ITYP_I_SP  = 7'b1100111;
  localparam logic [6:0] ITYP_LOAD  = 7'b0000011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [6:0] op;
    logic [9:0] func;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I field and immediate extraction.
// Immediates are sign-extended to XLEN; illegal words yield imm = 0.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       sgn;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign sgn = instr[31];

  fmt_e fmt;
  logic known;
  logic bad;
  logic illegal;
  logic shift_i;

  // Classify opcode into an instruction format
  always_comb begin
    fmt   = FMT_I;
    known = 1'b1;
    unique case (opc)
      ITYP_R:                         fmt = FMT_R;
      ITYP_I, ITYP_LOAD, ITYP_I_SP:   fmt = FMT_I;
      ITYP_S:                         fmt = FMT_S;
      ITYP_B:                         fmt = FMT_B;
      ITYP_U, ITYP_AUIPC:             fmt = FMT_U;
      ITYP_J:                         fmt = FMT_J;
      default:                        known = 1'b0;
    endcase
  end

  assign shift_i = (opc == ITYP_I) &&
                   (f3 == F3_SLL || f3 == F3_SRL);

  // Reject funct combinations that RV32I does not define
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      opc == ITYP_R:
        bad = !(f7 == F7_ZERO ||
                (f7 == F7_ALT &&
                 (f3 == F3_ADD || f3 == F3_SRL)));
      opc == ITYP_I && f3 == F3_SLL:
        bad = f7 != F7_ZERO;
      opc == ITYP_I && f3 == F3_SRL:
        bad = f7 != F7_ZERO && f7 != F7_ALT;
      opc == ITYP_B:
        bad = f3 == 3'b010 || f3 == 3'b011;
      opc == ITYP_S:
        bad = f3 > 3'b010;
      opc == ITYP_I_SP:
        bad = f3 != 3'b000;
      default:
        bad = 1'b0;
    endcase
  end

  assign illegal = !known || bad;

  logic signed [31:0] imm32;

  // Assemble the 32-bit immediate for the format
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I: imm32 = {{20{sgn}}, instr[31:20]};
      FMT_S: imm32 = {{20{sgn}}, instr[31:25],
                      instr[11:7]};
      FMT_B: imm32 = {{19{sgn}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{sgn}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = illegal ? '0 : XLEN'(imm32);

  // Select register fields and funct bits by format
  always_comb begin
    dec.op      = opc;
    dec.illegal = illegal;
    dec.func    = '0;
    dec.rs1     = '0;
    dec.rs2     = '0;
    dec.rd      = '0;
    if (illegal) begin
      dec.func = {f7, f3};
      dec.rs1  = instr[19:15];
      dec.rs2  = instr[24:20];
      dec.rd   = instr[11:7];
    end else begin
      unique case (fmt)
        FMT_R: begin
          dec.func = {f7, f3};
          dec.rs1  = instr[19:15];
          dec.rs2  = instr[24:20];
          dec.rd   = instr[11:7];
        end
        FMT_I: begin
          dec.func = shift_i ? {f7, f3}
                             : {7'b0, f3};
          dec.rs1  = instr[19:15];
          dec.rd   = instr[11:7];
        end
        FMT_S, FMT_B: begin
          dec.func = {7'b0, f3};
          dec.rs1  = instr[19:15];
          dec.rs2  = instr[24:20];
        end
        FMT_U, FMT_J: begin
          dec.rd = instr[11:7];
        end
        default: begin
          dec.func = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides.
// Optional DECODE_PERF_EN adds emit / illegal-emit counters.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_op,
  output logic [9:0]      out_func,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
`ifdef DECODE_PERF_EN
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal,
`endif
  output logic [XLEN-1:0] out_pc
);

  dec_t            dec_n;
  logic [XLEN-1:0] imm_n;

  decode_comb #(
    .XLEN(XLEN)
  ) u_comb (
    .instr(in_instr),
    .dec  (dec_n),
    .imm  (imm_n)
  );

  dec_t            main_dec;
  logic [XLEN-1:0] main_imm;
  logic [XLEN-1:0] main_pc;
  logic            main_valid;
  logic            accept;
  logic            emit;

  assign accept = in_valid & in_ready;
  assign emit   = main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      dec_t            skid_dec;
      logic [XLEN-1:0] skid_imm;
      logic [XLEN-1:0] skid_pc;
      logic            skid_valid;

      assign in_ready = ~skid_valid;

      // Main register refills from skid first, so order is preserved
      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_dec   <= '0;
          main_imm   <= '0;
          main_pc    <= '0;
          skid_valid <= 1'b0;
          skid_dec   <= '0;
          skid_imm   <= '0;
          skid_pc    <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (emit || !main_valid) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_dec   <= skid_dec;
            main_imm   <= skid_imm;
            main_pc    <= skid_pc;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= accept;
            if (accept) begin
              main_dec <= dec_n;
              main_imm <= imm_n;
              main_pc  <= in_pc;
            end
          end
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_dec   <= dec_n;
          skid_imm   <= imm_n;
          skid_pc    <= in_pc;
        end
      end
    end else begin : g_single
      assign in_ready = out_ready | ~main_valid;

      // Single register loads whenever it is free or draining
      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_dec   <= '0;
          main_imm   <= '0;
          main_pc    <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (emit || !main_valid) begin
          main_valid <= accept;
          if (accept) begin
            main_dec <= dec_n;
            main_imm <= imm_n;
            main_pc  <= in_pc;
          end
        end
      end
    end
  endgenerate

  assign out_valid   = main_valid;
  assign out_op      = main_dec.op;
  assign out_func    = main_dec.func;
  assign out_rs1     = main_dec.rs1;
  assign out_rs2     = main_dec.rs2;
  assign out_rd      = main_dec.rd;
  assign out_illegal = main_dec.illegal;
  assign out_imm     = main_imm;
  assign out_pc      = main_pc;

`ifdef DECODE_PERF_EN
  // Count emits and illegal emits; flush leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (emit) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (main_dec.illegal)
        perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage (XLEN=32, SKID=1).
// Perf counter checks compile in when DECODE_PERF_EN is defined.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  out_op;
  logic [9:0]  out_func;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [31:0] out_pc;
`ifdef DECODE_PERF_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_illegal;
`endif

  int pass = 0;
  int total = 0;

  decode_stage #(
    .XLEN(32),
    .SKID(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_func   (out_func),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_illegal(out_illegal),
`ifdef DECODE_PERF_EN
    .perf_decoded(perf_decoded),
    .perf_illegal(perf_illegal),
`endif
    .out_pc     (out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  task automatic send(input logic [31:0] ins,
                      input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready); else pass++;
    total++; if (out_imm !== 32'h0) $display("FAIL rst_imm got %h want 0", out_imm); else pass++;
    total++; if (out_op !== 7'h0) $display("FAIL rst_op got %h want 0", out_op); else pass++;
    total++; if (out_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", out_pc); else pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL addi_pre_valid got %0b want 0", out_valid); else pass++;
    send(32'h00500093, 32'h0000_0100);
    total++; if (out_valid !== 1'b1) $display("FAIL addi_latency got %0b want 1", out_valid); else pass++;
    total++; if (out_op !== ITYP_I) $display("FAIL addi_op got %h want %h", out_op, ITYP_I); else pass++;
    total++; if (out_func !== 10'h000) $display("FAIL addi_func got %h want 000", out_func); else pass++;
    total++; if (out_rs1 !== 5'd0) $display("FAIL addi_rs1 got %0d want 0", out_rs1); else pass++;
    total++; if (out_rs2 !== 5'd0) $display("FAIL addi_rs2 got %0d want 0", out_rs2); else pass++;
    total++; if (out_rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", out_rd); else pass++;
    total++; if (out_imm !== 32'd5) $display("FAIL addi_imm got %h want 5", out_imm); else pass++;
    total++; if (out_illegal !== 1'b0) $display("FAIL addi_illegal got %0b want 0", out_illegal); else pass++;
    total++; if (out_pc !== 32'h100) $display("FAIL addi_pc got %h want 100", out_pc); else pass++;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %0b want 0", out_valid); else pass++;
  endtask

  task automatic test_rtype_branch();
    out_ready = 1'b1;
    send(32'h402081B3, 32'h0000_0104);
    total++; if (out_op !== ITYP_R) $display("FAIL sub_op got %h want %h", out_op, ITYP_R); else pass++;
    total++; if (out_func !== 10'h100) $display("FAIL sub_func got %h want 100", out_func); else pass++;
    total++; if (out_rs1 !== 5'd1) $display("FAIL sub_rs1 got %0d want 1", out_rs1); else pass++;
    total++; if (out_rs2 !== 5'd2) $display("FAIL sub_rs2 got %0d want 2", out_rs2); else pass++;
    total++; if (out_rd !== 5'd3) $display("FAIL sub_rd got %0d want 3", out_rd); else pass++;
    send(32'hFE208EE3, 32'h0000_0108);
    total++; if (out_op !== ITYP_B) $display("FAIL beq_op got %h want %h", out_op, ITYP_B); else pass++;
    total++; if (out_imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm got %h want fffffffc", out_imm); else pass++;
    total++; if (out_rd !== 5'd0) $display("FAIL beq_rd got %0d want 0", out_rd); else pass++;
    total++; if (out_pc !== 32'h108) $display("FAIL beq_pc got %h want 108", out_pc); else pass++;
  endtask

  task automatic test_store_lui_jal();
    out_ready = 1'b1;
    send(32'hFE20AC23, 32'h0000_0200);
    total++; if (out_imm !== 32'hFFFF_FFF8) $display("FAIL sw_imm got %h want fffffff8", out_imm); else pass++;
    total++; if (out_rd !== 5'd0) $display("FAIL sw_rd got %0d want 0", out_rd); else pass++;
    total++; if (out_func !== 10'h002) $display("FAIL sw_func got %h want 002", out_func); else pass++;
    send(32'h123452B7, 32'h0000_0204);
    total++; if (out_imm !== 32'h1234_5000) $display("FAIL lui_imm got %h want 12345000", out_imm); else pass++;
    total++; if (out_rd !== 5'd5) $display("FAIL lui_rd got %0d want 5", out_rd); else pass++;
    send(32'h008000EF, 32'h0000_0208);
    total++; if (out_imm !== 32'd8) $display("FAIL jal_imm got %h want 8", out_imm); else pass++;
    total++; if (out_rd !== 5'd1) $display("FAIL jal_rd got %0d want 1", out_rd); else pass++;
    total++; if (out_op !== ITYP_J) $display("FAIL jal_op got %h want %h", out_op, ITYP_J); else pass++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h0000_0300);
    total++; if (out_illegal !== 1'b1) $display("FAIL ill_flag got %0b want 1", out_illegal); else pass++;
    total++; if (out_imm !== 32'h0) $display("FAIL ill_imm got %h want 0", out_imm); else pass++;
    total++; if (out_rd !== 5'd31) $display("FAIL ill_rd got %0d want 31", out_rd); else pass++;
    total++; if (out_valid !== 1'b1) $display("FAIL ill_valid got %0b want 1", out_valid); else pass++;
    send(32'h00209093, 32'h0000_0304);
    total++; if (out_illegal !== 1'b0) $display("FAIL slli_ok got %0b want 0", out_illegal); else pass++;
    send(32'h40209093, 32'h0000_0308);
    total++; if (out_illegal !== 1'b1) $display("FAIL slli_bad got %0b want 1", out_illegal); else pass++;
    send(32'h0020A063, 32'h0000_030C);
    total++; if (out_illegal !== 1'b1) $display("FAIL br_f3 got %0b want 1", out_illegal); else pass++;
    send(32'h40209033, 32'h0000_0310);
    total++; if (out_illegal !== 1'b1) $display("FAIL r_alt_sll got %0b want 1", out_illegal); else pass++;
    @(posedge clk);
    #1;
  endtask

`ifdef DECODE_PERF_EN
  task automatic test_perf();
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00500093, 32'h0);
    send(32'hFFFFFFFF, 32'h4);
    send(32'h402081B3, 32'h8);
    send(32'h008000EF, 32'hC);
    @(posedge clk);
    #1;
    total++; if (perf_decoded !== 32'd4) $display("FAIL perf_dec got %0d want 4", perf_decoded); else pass++;
    total++; if (perf_illegal !== 32'd1) $display("FAIL perf_ill got %0d want 1", perf_illegal); else pass++;
  endtask
`endif

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0010);
    total++; if (out_valid !== 1'b1) $display("FAIL bp_v1 got %0b want 1", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_rdy1 got %0b want 1", in_ready); else pass++;
    send(32'h00200113, 32'h0000_0014);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_rdy2 got %0b want 0", in_ready); else pass++;
    total++; if (out_rd !== 5'd1) $display("FAIL bp_hold_rd got %0d want 1", out_rd); else pass++;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h00300193;
    in_pc    = 32'h0000_0018;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_rdy3 got %0b want 0", in_ready); else pass++;
    total++; if (out_imm !== 32'd1) $display("FAIL bp_hold_imm got %h want 1", out_imm); else pass++;
    total++; if (out_pc !== 32'h10) $display("FAIL bp_hold_pc got %h want 10", out_pc); else pass++;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_rd !== 5'd2) $display("FAIL bp_emit2 got %0d want 2", out_rd); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_rdy4 got %0b want 1", in_ready); else pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (out_rd !== 5'd3) $display("FAIL bp_emit3 got %0d want 3", out_rd); else pass++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_v3 got %0b want 1", out_valid); else pass++;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_done got %0b want 0", out_valid); else pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0020);
    send(32'h00200113, 32'h0000_0024);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00300193;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL fl_valid got %0b want 0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL fl_in_ready got %0b want 1", in_ready); else pass++;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL fl_drop got %0b want 0", out_valid); else pass++;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL fl_after got %0b want 0", out_valid); else pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h123452B7, 32'h0000_0040);
    send(32'h00200113, 32'h0000_0044);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rm_valid got %0b want 0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got %0b want 1", in_ready); else pass++;
    total++; if (out_rd !== 5'd0) $display("FAIL rm_rd got %0d want 0", out_rd); else pass++;
    total++; if (out_imm !== 32'h0) $display("FAIL rm_imm got %h want 0", out_imm); else pass++;
    total++; if (out_pc !== 32'h0) $display("FAIL rm_pc got %h want 0", out_pc); else pass++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rm_skid_gone got %0b want 0", out_valid); else pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype_branch();
    test_store_lui_jal();
    test_illegal();
`ifdef DECODE_PERF_EN
    test_perf();
`endif
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
